// File: rtl/keypad_debouncer_if.sv
// Keypad debouncer signal bundle: raw scanner inputs in, debounced event and
// scan-hold control out.
interface keypad_debouncer_if;
    logic       key_active;
    logic [3:0] key_code;
    logic       scan_hold;
    logic [3:0] pressed_value;
    logic       new_value;
    logic [2:0] press_count;

    // master: scanner/display side; slave: the debouncer itself
    modport master (
        output key_active,
        output key_code,
        input  scan_hold,
        input  pressed_value,
        input  new_value,
        input  press_count
    );

    modport slave (
        input  key_active,
        input  key_code,
        output scan_hold,
        output pressed_value,
        output new_value,
        output press_count
    );
endinterface

// File: rtl/keypad_debouncer.sv
// Synchronises the raw keypad indication and code, qualifies a press and a release
// over debounce_delay stable cycles, and emits one new_value strobe per press.
module keypad_debouncer #(
    parameter int unsigned debounce_delay = 100000
) (
    input logic               clk,
    input logic               reset,
    keypad_debouncer_if.slave kp
);
    localparam int unsigned     cnt_w    = $clog2(debounce_delay + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(debounce_delay - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRelDb
    } state_t;

    logic             key_active_m;
    logic             key_active_s;
    logic [3:0]       key_code_m;
    logic [3:0]       key_code_s;

    state_t           state;
    logic [cnt_w-1:0] counter;
    logic [3:0]       candidate;
    logic [3:0]       pressed_value;
    logic             new_value;
    logic             scan_hold;
    logic [2:0]       press_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_active_m <= 1'b0;
            key_active_s <= 1'b0;
            key_code_m   <= 4'h0;
            key_code_s   <= 4'h0;
        end else begin
            key_active_m <= kp.key_active;
            key_active_s <= key_active_m;
            key_code_m   <= kp.key_code;
            key_code_s   <= key_code_m;
        end
    end

    // Every transition clears counter, so each debounce window restarts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            counter       <= '0;
            candidate     <= 4'h0;
            pressed_value <= 4'h0;
            new_value     <= 1'b0;
            scan_hold     <= 1'b0;
            press_count   <= 3'd0;
        end else begin
            new_value <= 1'b0;
            case (state)
                StIdle: begin
                    if (key_active_s) begin
                        candidate <= key_code_s;
                        counter   <= '0;
                        scan_hold <= 1'b1;
                        state     <= StPressDb;
                    end
                end
                StPressDb: begin
                    if (!key_active_s || (key_code_s != candidate)) begin
                        counter   <= '0;
                        scan_hold <= 1'b0;
                        state     <= StIdle;
                    end else if (counter == cnt_last) begin
                        counter       <= '0;
                        pressed_value <= candidate;
                        new_value     <= 1'b1;
                        press_count   <= press_count + 3'd1;
                        state         <= StHeld;
                    end else begin
                        counter <= counter + cnt_w'(1);
                    end
                end
                StHeld: begin
                    // A second key changing key_code while held is deliberately ignored.
                    if (!key_active_s) begin
                        counter <= '0;
                        state   <= StRelDb;
                    end
                end
                StRelDb: begin
                    if (key_active_s) begin
                        counter <= '0;
                        state   <= StHeld;
                    end else if (counter == cnt_last) begin
                        counter   <= '0;
                        scan_hold <= 1'b0;
                        state     <= StIdle;
                    end else begin
                        counter <= counter + cnt_w'(1);
                    end
                end
                default: begin
                    counter   <= '0;
                    scan_hold <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

    assign kp.scan_hold     = scan_hold;
    assign kp.pressed_value = pressed_value;
    assign kp.new_value     = new_value;
    assign kp.press_count   = press_count;
endmodule

// File: tb/tb_keypad_debouncer.sv
// Bench for keypad_debouncer: hand timing sequences, a scenario table and random
// stimulus, all checked against a run-length reference model.
module tb_keypad_debouncer;
    localparam int unsigned dly = 4;

    logic clk = 1'b0;
    logic reset;

    keypad_debouncer_if kp ();

    keypad_debouncer #(
        .debounce_delay(dly)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int strobes;

    // Reference model: qualification as counted runs of synchronised samples.
    logic       hist_a[$];
    logic [3:0] hist_c[$];
    bit         m_held;
    int         m_run;
    logic [3:0] m_cand;
    logic [3:0] m_pv;
    logic [2:0] m_cnt;
    logic       m_nv;

    typedef struct {
        logic       act;
        logic [3:0] code;
        int         cycles;
        int         exp_strobes;
        logic       exp_hold;
        logic [3:0] exp_pv;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[13];

    function automatic void model_reset();
        hist_a = '{1'b0, 1'b0};
        hist_c = '{4'h0, 4'h0};
        m_held = 1'b0;
        m_run  = 0;
        m_cand = 4'h0;
        m_pv   = 4'h0;
        m_cnt  = 3'd0;
        m_nv   = 1'b0;
    endfunction

    function automatic void model_edge(logic a, logic [3:0] c);
        logic       da;
        logic [3:0] dc;
        da = hist_a.pop_front();
        dc = hist_c.pop_front();
        hist_a.push_back(a);
        hist_c.push_back(c);
        m_nv = 1'b0;
        if (!m_held) begin
            if (m_run == 0) begin
                if (da) begin
                    m_cand = dc;
                    m_run  = 1;
                end
            end else if (da && dc == m_cand) begin
                m_run++;
                if (m_run == int'(dly) + 1) begin
                    m_held = 1'b1;
                    m_run  = 0;
                    m_nv   = 1'b1;
                    m_pv   = m_cand;
                    m_cnt  = m_cnt + 3'd1;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (da) m_run = 0;
            else m_run++;
            if (m_run == int'(dly) + 1) begin
                m_held = 1'b0;
                m_run  = 0;
            end
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        int got;
        int exp;
        @(posedge clk);
        model_edge(kp.key_active, kp.key_code);
        @(negedge clk);
        if (kp.new_value === 1'b1) strobes++;
        got = int'({kp.scan_hold, kp.pressed_value, kp.new_value, kp.press_count});
        exp = int'({(m_held || m_run != 0), m_pv, m_nv, m_cnt});
        check("model {hold,pv,nv,cnt}", got, exp);
    endtask

    task automatic drive(input logic a, input logic [3:0] c);
        kp.key_active = a;
        kp.key_code   = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        vecs[0]  = '{1'b1, 4'hA, 3,  0, 1'b1, 4'h7, 3'd1};
        vecs[1]  = '{1'b0, 4'hA, 1,  0, 1'b1, 4'h7, 3'd1};
        vecs[2]  = '{1'b1, 4'hA, 12, 1, 1'b1, 4'hA, 3'd2};
        vecs[3]  = '{1'b0, 4'hA, 10, 0, 1'b0, 4'hA, 3'd2};
        vecs[4]  = '{1'b1, 4'h3, 4,  0, 1'b1, 4'hA, 3'd2};
        vecs[5]  = '{1'b1, 4'h5, 12, 1, 1'b1, 4'h5, 3'd3};
        vecs[6]  = '{1'b1, 4'h5, 50, 0, 1'b1, 4'h5, 3'd3};
        vecs[7]  = '{1'b0, 4'h5, 3,  0, 1'b1, 4'h5, 3'd3};
        vecs[8]  = '{1'b1, 4'h5, 2,  0, 1'b1, 4'h5, 3'd3};
        vecs[9]  = '{1'b0, 4'h5, 12, 0, 1'b0, 4'h5, 3'd3};
        vecs[10] = '{1'b1, 4'h1, 10, 1, 1'b1, 4'h1, 3'd4};
        vecs[11] = '{1'b1, 4'h2, 10, 0, 1'b1, 4'h1, 3'd4};
        vecs[12] = '{1'b0, 4'h2, 10, 0, 1'b0, 4'h1, 3'd4};

        reset = 1'b0;
        drive(1'b0, 4'h0);
        model_reset();
        strobes = 0;
        @(negedge clk);
        check("reset scan_hold", int'(kp.scan_hold), 0);
        check("reset pressed_value", int'(kp.pressed_value), 0);
        check("reset new_value", int'(kp.new_value), 0);
        check("reset press_count", int'(kp.press_count), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Clean press: hold rises at E3, strobe only at E7.
        drive(1'b1, 4'h7);
        for (int e = 1; e <= 9; e++) begin
            step();
            check($sformatf("clean hold e%0d", e), int'(kp.scan_hold), (e >= 3) ? 1 : 0);
            check($sformatf("clean nv e%0d", e), int'(kp.new_value), (e == 7) ? 1 : 0);
        end
        check("clean pressed_value", int'(kp.pressed_value), 7);
        check("clean press_count", int'(kp.press_count), 1);
        drive(1'b0, 4'h7);
        for (int r = 1; r <= 9; r++) begin
            step();
            check($sformatf("release hold r%0d", r), int'(kp.scan_hold), (r < 7) ? 1 : 0);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].act, vecs[i].code);
            strobes = 0;
            for (int k = 0; k < vecs[i].cycles; k++) step();
            check($sformatf("vec%0d strobes", i), strobes, vecs[i].exp_strobes);
            check($sformatf("vec%0d hold", i), int'(kp.scan_hold), int'(vecs[i].exp_hold));
            check($sformatf("vec%0d pv", i), int'(kp.pressed_value), int'(vecs[i].exp_pv));
            check($sformatf("vec%0d cnt", i), int'(kp.press_count), int'(vecs[i].exp_cnt));
        end

        // Reset in PRESS_DB with counter at 2, key kept held.
        drive(1'b1, 4'h9);
        for (int k = 0; k < 5; k++) step();
        #2 reset = 1'b0;
        #1;
        check("midrst scan_hold", int'(kp.scan_hold), 0);
        check("midrst pressed_value", int'(kp.pressed_value), 0);
        check("midrst new_value", int'(kp.new_value), 0);
        check("midrst press_count", int'(kp.press_count), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (kp.new_value === 1'b1) begin
                n = e;
                break;
            end
        end
        check("midrst strobe edge", n, int'(dly) + 3);
        check("midrst pv", int'(kp.pressed_value), 9);
        check("midrst cnt", int'(kp.press_count), 1);

        for (int p = 0; p < 7; p++) begin
            drive(1'b0, 4'h0);
            for (int k = 0; k < 10; k++) step();
            drive(1'b1, 4'(p));
            for (int k = 0; k < 10; k++) step();
        end
        check("wrap press_count", int'(kp.press_count), 0);
        check("wrap pv", int'(kp.pressed_value), 6);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(5) == 0) kp.key_active = ~kp.key_active;
            if ($urandom_range(9) == 0) kp.key_code = 4'($urandom_range(15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_debouncer.md
# keypad_debouncer

Converts the raw "key seen" indication and key code from the column-scanning logic into one clean, debounced keypress event. The block sits between the keypad scanner and the dual seven-segment display path. It synchronises the asynchronous keypad-derived inputs and tells the scanner to freeze its column drive while a key is being qualified or held. It emits a one-cycle `new_value` strobe with a stable `pressed_value`, which the display path consumes.

## Interface

Parameters:
- `debounce_delay`, default 100000: number of consecutive clock cycles an input must be stable to qualify a press or a release. Legal range is at least 2.

Ports:
- `clk`  input  1  system clock from the HSOSC domain.
- `reset`  input  1  asynchronous, active-low reset.
- `key_active`  input  1  asynchronous; 1 when any row reads pressed in the currently driven column.
- `key_code`  input  4  asynchronous; hex code (0x0–0xF) decoded from the current row and column.
- `scan_hold`  output  1  1 means the scanner must stop advancing columns.
- `pressed_value`  output  4  code of the last qualified press.
- `new_value`  output  1  one-cycle strobe marking a new qualified press.
- `press_count`  output  3  debug counter of qualified presses; wraps 7→0.

## Operation

Clock and reset:
- One clock, `clk`.
- `reset` is asynchronous and active-low.

Input synchronisers:
- `key_active` and `key_code` each pass through a 2-flop synchroniser, giving `key_active_s` and `key_code_s`.
- All state machine decisions use only the synchronised values.

Registers:
- `candidate` (4 bits).
- `counter`, width $clog2(debounce_delay+1). It is cleared on every state change.

State machine (`scan_hold` is 0 only in IDLE):
- **IDLE**
  - When `key_active_s`=1: load `candidate`←`key_code_s` and go to PRESS_DB.
- **PRESS_DB**
  - `key_active_s`=0, or `key_code_s`≠`candidate`: go back to IDLE. No strobe.
  - Otherwise, if `counter`==`debounce_delay`-1: go to HELD, load `pressed_value`←`candidate`, pulse `new_value`=1 for one cycle, and increment `press_count`.
  - Otherwise: `counter`++.
- **HELD**
  - When `key_active_s`=0: go to REL_DB.
  - Changes in `key_code_s` while `key_active_s`=1 are ignored, so a second simultaneous key produces no event.
- **REL_DB**
  - `key_active_s`=1: go back to HELD. This is a release bounce and produces no strobe.
  - Otherwise, if `counter`==`debounce_delay`-1: go to IDLE.
  - Otherwise: `counter`++.

Output rules:
- `new_value` is high for exactly one cycle per qualified press, never in consecutive cycles.
- `pressed_value` changes only in the cycle in which `new_value` rises, and holds otherwise.

Reset:
- Asserting `reset` at any time, including mid-debounce, forces all of the following immediately and asynchronously: state IDLE, `counter`=0, `candidate`=0, `pressed_value`=0, `new_value`=0, `press_count`=0, `scan_hold`=0, synchroniser flops 0.
- After `reset` deasserts, the first possible strobe takes a full qualification.

## Timing

Edge numbering: E1 is the first rising edge that samples `key_active`=1 into the synchroniser, with the inputs stable from before E1.
- E2: `key_active_s`=1.
- E3: state becomes PRESS_DB, `counter`=0, `scan_hold`=1.
- E(3+k): `counter`=k.
- E(3+debounce_delay): state becomes HELD, `new_value`=1 and `pressed_value` is valid. `new_value` falls at the next edge.
- Press latency: `new_value` rises `debounce_delay`+2 edges after E1.

Release follows the same numbering: the first low sample is R1, state becomes REL_DB at R3, and state returns to IDLE (`scan_hold`=0) at R(3+debounce_delay).

- Bounce window: any single-cycle glitch in `key_active_s` during PRESS_DB restarts qualification from IDLE.
- Minimum time between two strobes: 2·`debounce_delay`+5 edges.

## Test plan

Run all scenarios with `debounce_delay`=4.

- **Clean press:** `key_active`=1 and `key_code`=0x7 held from before E1, with `reset` deasserted → `scan_hold` rises at E3, `new_value` is high for exactly one cycle after E7, `pressed_value`=0x7, `press_count`=1.
- **Press bounce:** `key_active` goes 1 for 3 cycles, 0 for 1 cycle, then 1 steadily with `key_code`=0xA → no strobe for the short burst. A single strobe follows, with `pressed_value`=0xA, 6 edges after the stable high is first sampled.
- **Code change during qualification:** `key_code` switches from 0x3 to 0x5 while in PRESS_DB → restart through IDLE. Exactly one strobe, with `pressed_value`=0x5.
- **Hold and release with bounce:** hold the key for 50 cycles, then release with a 2-cycle high glitch inside REL_DB → only one strobe. `scan_hold` falls 6 edges after the final stable low is first sampled.
- **Second key while held:** in HELD, `key_code` changes from 0x1 to 0x2 with `key_active` staying 1 → no strobe, and `pressed_value` stays 0x1.
- **Reset mid-operation:** pulse `reset` low during PRESS_DB (counter=2) → all outputs are 0 immediately. With the key still held, a strobe occurs `debounce_delay`+2 edges after the first post-reset sampling edge. Eight qualified presses bring `press_count` back to 0.
